mc_ctrl: RTL

Multi-cycle main control FSM for the RV32I subset core: sequences instruction fetch, decode, ALU execute, memory access and register write-back over a single shared memory port and the single ALU. It sits beside the ALU control unit: the ALU control unit picks the ALU operation from opcode/funct fields, and this block produces every enable, mux select and memory handshake around it. It also keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I subset core.
// Holds the main-control state encoding, the legal opcode constants and the
// datapath mux select encodings. ALU op codes live in defines.svh and are not
// repeated here.
package cpu_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 7;

  // Main control FSM states; the encoding is visible on state_o for debug.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_IALU  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;

  localparam logic ADDR_SEL_PC   = 1'b0;
  localparam logic ADDR_SEL_ALU  = 1'b1;
  localparam logic ALU_SRC_B_RS2 = 1'b0;
  localparam logic ALU_SRC_B_IMM = 1'b1;
  localparam logic WB_SEL_ALU    = 1'b0;
  localparam logic WB_SEL_MDR    = 1'b1;

  // True for the four opcodes this core executes.
  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_IALU) ||
           (opc == OPC_LOAD)  || (opc == OPC_STORE);
  endfunction

  // True for opcodes that need the data memory phase.
  function automatic logic is_mem_opcode(input logic [OPCODE_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM.
// Sequences fetch, decode, execute, memory access and write-back over one
// shared memory port, and counts retired instructions.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   opcode_i            opcode of the latched instruction register
//   mem_ready_i         memory completes the current request this cycle
//   mem_req_o/mem_we_o  memory request / write strobe (held until ready)
//   addr_sel_o          memory address select (PC or ALU result register)
//   ir_we_o, pc_we_o    instruction register load, PC <- PC+4
//   alu_out_we_o        ALU result register load
//   alu_src_b_o         ALU operand B select (rs2 or immediate)
//   mdr_we_o            memory data register load
//   rf_we_o, wb_sel_o   register file write enable and source select
//   state_o             current state (debug)
//   instret_o           retired-instruction count, wraps
//   trap_o              illegal-instruction trap
//
// Build option: define MC_CTRL_TRAP_EN to trap on an illegal opcode; without
// it an illegal opcode retires nothing and behaves as a NOP.
//
// Control outputs are decoded from the current state and mem_ready_i, so a
// reset drops a pending memory request in the same cycle.
module mc_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 addr_sel_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 alu_out_we_o,
  output logic                 alu_src_b_o,
  output logic                 mdr_we_o,
  output logic                 rf_we_o,
  output logic                 wb_sel_o,
  output logic [STATE_W-1:0]   state_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 trap_o
);

  state_e                state_q, state_d;
  logic [INSTRET_W-1:0]  instret_q;
  logic                  retire;

  // State and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = ADDR_SEL_PC;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    alu_out_we_o = 1'b0;
    alu_src_b_o  = ALU_SRC_B_RS2;
    mdr_we_o     = 1'b0;
    rf_we_o      = 1'b0;
    wb_sel_o     = WB_SEL_ALU;
    trap_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req_o  = 1'b1;
        addr_sel_o = ADDR_SEL_PC;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_legal_opcode(opcode_i)) begin
          state_d = ST_EXEC;
        end else begin
`ifdef MC_CTRL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end
      end

      ST_EXEC: begin
        alu_out_we_o = 1'b1;
        alu_src_b_o  = (opcode_i == OPC_RTYPE) ? ALU_SRC_B_RS2 : ALU_SRC_B_IMM;
        state_d      = is_mem_opcode(opcode_i) ? ST_MEM : ST_WB;
      end

      ST_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = ADDR_SEL_ALU;
        mem_we_o   = (opcode_i == OPC_STORE);
        if (mem_ready_i) begin
          if (opcode_i == OPC_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            mdr_we_o = 1'b1;
            state_d  = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (opcode_i == OPC_LOAD) ? WB_SEL_MDR : WB_SEL_ALU;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

`ifdef MC_CTRL_TRAP_EN
      // Sticky until reset.
      ST_TRAP: begin
        trap_o = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule
